addsub_issue: RTL and testbench
===============================

# addsub_issue

Operand issue queue directly upstream of the 8-bit `addsub` stage. It buffers operation requests (dataa, datab, add_sub) arriving on a valid/ready interface and issues at most one per cycle onto the `addsub` operand inputs. It also generates a result-valid strobe and sequence tag aligned with the `addsub` registered `result`, so downstream logic knows which cycle carries which operation's answer.

## Interface
- `WIDTH`, 8: operand width; must match the `addsub` data width.
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `TAG_W`, 4: sequence tag width.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  queue can accept; combinational.
- `in_dataa`  in  WIDTH  operand A.
- `in_datab`  in  WIDTH  operand B.
- `in_add_sub`  in  1  1 = add, 0 = subtract.
- `issue_en`  in  1  downstream permits issue this cycle.
- `op_dataa`  out  WIDTH  registered; to `addsub.dataa`.
- `op_datab`  out  WIDTH  registered; to `addsub.datab`.
- `op_add_sub`  out  1  registered; to `addsub.add_sub`.
- `op_valid`  out  1  registered; op_* carry a newly issued operation.
- `op_tag`  out  TAG_W  registered; tag of the issued operation.
- `res_valid`  out  1  registered; `addsub.result` is valid this cycle.
- `res_tag`  out  TAG_W  registered; tag matching `res_valid`.
- `count`  out  clog2(DEPTH)+1  registered occupancy.

## Operation
- **Storage:** circular buffer of DEPTH entries of {add_sub, dataa, datab}, with write pointer, read pointer and `count`. Pointers wrap DEPTH-1 → 0.
- **Push:** occurs when `in_valid && in_ready`.
  - `in_ready = !reset && (count < DEPTH)`.
  - There is no pop-through: a full queue deasserts `in_ready` even if a pop occurs in the same cycle.
- **Pop / issue:** occurs when `issue_en && count != 0`. At that edge:
  - op_dataa/op_datab/op_add_sub load the head entry.
  - `op_valid` ← 1, `op_tag` ← `tag_ctr`.
  - `tag_ctr` increments, wrapping 2^TAG_W-1 → 0.
- **No pop:** `op_valid` ← 0; op_data, op_add_sub and `op_tag` hold their last values.
- **Simultaneous push and pop:** `count` is unchanged; both pointers advance.
- **Empty queue:** there is no bypass. A request pushed into an empty queue is popped no earlier than the next edge.
- **Result alignment:** `res_valid` ← `op_valid`; `res_tag` ← `op_tag`. Every edge updates these, so they mirror the one-cycle `addsub` latency.
- **Arithmetic:** the block performs none. Operands pass through unmodified; wrap-around of the result is the `addsub` stage's modulo-2^WIDTH behaviour.
- **Reset:** asserting `reset` at any edge, including mid-stream, clears the following and discards queued and in-flight operations:
  - pointers, `count`, `tag_ctr` → 0;
  - op_dataa, op_datab, op_add_sub, op_tag, res_tag → 0;
  - `op_valid`, `res_valid` → 0.
- **During reset:** pushes are ignored and `in_ready` is 0. The `addsub` result register is not reset; `res_valid` = 0 masks it.

## Timing
- **Request path:**
  - Edge T: request accepted.
  - After edge T+1 (earliest): `op_valid` = 1.
  - Edge T+2: `addsub` registers the result; after T+2, `res_valid` = 1 with the same tag.
- **Throughput:** one operation per cycle sustained when `issue_en` is held high and `in_valid` is continuous.
- **Order:** issue order equals acceptance order. Tags are strictly consecutive modulo 2^TAG_W.
- **`issue_en` low:** no pop. The stall propagates to `res_valid` one cycle later.
- **`in_ready` timing:** drops in the cycle after the DEPTH-th outstanding push and rises in the cycle after a pop.

## Test plan
- **Single op:** reset, then push (a=0x10, b=0x05, add) with `issue_en` = 1.
  - Expect `op_valid` one cycle later, with op_dataa=0x10, op_datab=0x05, op_tag=0.
  - Expect `res_valid` the next cycle, with res_tag=0 and `addsub.result` = 0x15.
- **Back-to-back stream:** push 6 ops continuously with `issue_en` = 1; include (0xFF+0x01) and (0x00-0x01).
  - Expect `res_valid` high for 6 consecutive cycles with tags 0–5.
  - Expect results in order, with 0x00 and 0xFF at the wrap cases.
- **Full queue:** hold `issue_en` = 0 and push 5 ops.
  - Expect `in_ready` = 0 after 4 pushes and `count` = 4; the 5th op is not accepted.
  - Raise `issue_en`: 4 ops issue in order, and `in_ready` returns 1 one cycle after the first pop.
- **Simultaneous push/pop:** at `count` = 2, push and pop in the same cycle.
  - Expect `count` to stay 2 and ordering to be preserved.
- **Tag wrap:** issue 18 ops.
  - Expect tags 0..15, then 0, 1.
- **Reset mid-operation:** with `count` = 3 and `op_valid`/`res_valid` high, assert `reset` for one cycle.
  - Next cycle: all outputs 0, `count` = 0, no `res_valid` for the discarded ops.
  - The next accepted op carries tag 0.

Source files
------------

// File: rtl/addsub_issue_if.sv
// Request, issue and result-tag signals between the addsub issue queue and its neighbours.
// The master side supplies requests and issue permission; the slave side is the queue.
interface addsub_issue_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_dataa;
    logic [WIDTH-1:0] in_datab;
    logic             in_add_sub;
    logic             issue_en;
    logic [WIDTH-1:0] op_dataa;
    logic [WIDTH-1:0] op_datab;
    logic             op_add_sub;
    logic             op_valid;
    logic [TAG_W-1:0] op_tag;
    logic             res_valid;
    logic [TAG_W-1:0] res_tag;
    logic [CNT_W-1:0] count;

    modport master (
        output in_valid, in_dataa, in_datab, in_add_sub, issue_en,
        input  in_ready, op_dataa, op_datab, op_add_sub, op_valid, op_tag,
               res_valid, res_tag, count
    );

    modport slave (
        input  in_valid, in_dataa, in_datab, in_add_sub, issue_en,
        output in_ready, op_dataa, op_datab, op_add_sub, op_valid, op_tag,
               res_valid, res_tag, count
    );
endinterface

// File: rtl/addsub_issue.sv
// Operand issue queue feeding the registered addsub stage, with a result-valid strobe
// and sequence tag delayed one cycle to line up with the addsub result register.
module addsub_issue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic          clk,
    input  logic          reset,
    addsub_issue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_a  [DEPTH];
    logic [WIDTH-1:0] mem_b  [DEPTH];
    logic             mem_op [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic [TAG_W-1:0] tag_ctr;

    logic [WIDTH-1:0] op_dataa_q;
    logic [WIDTH-1:0] op_datab_q;
    logic             op_add_sub_q;
    logic             op_valid_q;
    logic [TAG_W-1:0] op_tag_q;
    logic             res_valid_q;
    logic [TAG_W-1:0] res_tag_q;

    logic ready;
    logic push;
    logic pop;

    // Readiness looks only at the registered occupancy, so a full queue stays closed
    // even when an issue drains an entry in the same cycle.
    always_comb begin
        ready = !reset && (count_q < CNT_W'(DEPTH));
        push  = bus.in_valid && ready;
        pop   = bus.issue_en && (count_q != '0);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]  <= bus.in_dataa;
            mem_b[wr_ptr]  <= bus.in_datab;
            mem_op[wr_ptr] <= bus.in_add_sub;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count_q      <= '0;
            tag_ctr      <= '0;
            op_dataa_q   <= '0;
            op_datab_q   <= '0;
            op_add_sub_q <= 1'b0;
            op_valid_q   <= 1'b0;
            op_tag_q     <= '0;
            res_valid_q  <= 1'b0;
            res_tag_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end

            // Operand registers hold their last values when nothing issues.
            if (pop) begin
                rd_ptr       <= rd_ptr + PTR_W'(1);
                op_dataa_q   <= mem_a[rd_ptr];
                op_datab_q   <= mem_b[rd_ptr];
                op_add_sub_q <= mem_op[rd_ptr];
                op_tag_q     <= tag_ctr;
                op_valid_q   <= 1'b1;
                tag_ctr      <= tag_ctr + TAG_W'(1);
            end else begin
                op_valid_q   <= 1'b0;
            end

            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CNT_W'(1);
            end

            res_valid_q <= op_valid_q;
            res_tag_q   <= op_tag_q;
        end
    end

    assign bus.in_ready   = ready;
    assign bus.op_dataa   = op_dataa_q;
    assign bus.op_datab   = op_datab_q;
    assign bus.op_add_sub = op_add_sub_q;
    assign bus.op_valid   = op_valid_q;
    assign bus.op_tag     = op_tag_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_tag    = res_tag_q;
    assign bus.count      = count_q;
endmodule

// File: tb/tb_addsub_issue.sv
// Scoreboard bench for addsub_issue: a queue-level occupancy model predicts acceptance,
// and a negedge monitor checks issued operands, tags and the downstream addsub result.
module tb_addsub_issue;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             op;
        logic [WIDTH-1:0] res;
    } req_t;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] res;
    } rsp_t;

    logic clk;
    logic reset;
    logic [WIDTH-1:0] dn_result;

    req_t exp_q[$];
    rsp_t res_q[$];

    int n_cmp = 0;
    int n_err = 0;
    int model_count = 0;
    int ops_seen = 0;
    logic [TAG_W-1:0] tag_model = '0;
    bit res_due = 1'b0;

    addsub_issue_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

    addsub_issue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Stand-in for the registered addsub stage downstream (its result register has no reset).
    always @(posedge clk) begin
        dn_result <= bus.op_add_sub ? (bus.op_dataa + bus.op_datab)
                                    : (bus.op_dataa - bus.op_datab);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reportUnexpected(input string name);
        n_cmp++;
        n_err++;
        $display("[TB] FAIL %s: got a valid strobe, expected none (scoreboard empty) at %0t", name, $time);
    endtask

    // Drives one cycle of inputs, checks occupancy/readiness against the model and
    // records accepted requests; returns one cycle later just after the negedge.
    task automatic applyStimulus(input bit valid, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input bit op, input bit issue);
        bit   m_push;
        bit   m_pop;
        req_t e;
        bus.in_valid   = valid;
        bus.in_dataa   = a;
        bus.in_datab   = b;
        bus.in_add_sub = op;
        bus.issue_en   = issue;
        #1;
        checkOutput("count", 32'(bus.count), 32'(model_count));
        checkOutput("in_ready", 32'(bus.in_ready), 32'(model_count < DEPTH));
        m_push = valid && (model_count < DEPTH);
        m_pop  = issue && (model_count != 0);
        if (m_push) begin
            e.a   = a;
            e.b   = b;
            e.op  = op;
            e.res = op ? WIDTH'(int'(a) + int'(b)) : WIDTH'(int'(a) - int'(b));
            exp_q.push_back(e);
        end
        model_count = model_count + int'(m_push) - int'(m_pop);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit issue);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, '0, '0, 1'b0, issue);
        end
    endtask

    task automatic applyReset();
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.issue_en = 1'b0;
        exp_q.delete();
        res_q.delete();
        model_count = 0;
        tag_model   = '0;
        res_due     = 1'b0;
        #1;
        checkOutput("in_ready_during_reset", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("rst_op_valid", 32'(bus.op_valid), 32'd0);
        checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("rst_op_dataa", 32'(bus.op_dataa), 32'd0);
        checkOutput("rst_op_datab", 32'(bus.op_datab), 32'd0);
        checkOutput("rst_op_add_sub", 32'(bus.op_add_sub), 32'd0);
        checkOutput("rst_op_tag", 32'(bus.op_tag), 32'd0);
        checkOutput("rst_res_tag", 32'(bus.res_tag), 32'd0);
        checkOutput("rst_count", 32'(bus.count), 32'd0);
        @(negedge clk);
        #1;
    endtask

    // Monitor: samples on the falling edge, pairs each issued operation with the oldest
    // accepted request and each result strobe with the operation issued a cycle before.
    initial begin
        req_t e;
        rsp_t r;
        forever begin
            @(negedge clk);
            checkOutput("res_valid_align", 32'(bus.res_valid), 32'(res_due));
            if (bus.res_valid) begin
                if (res_q.size() == 0) begin
                    reportUnexpected("res_valid_spurious");
                end else begin
                    r = res_q.pop_front();
                    checkOutput("res_tag", 32'(bus.res_tag), 32'(r.tag));
                    checkOutput("addsub_result", 32'(dn_result), 32'(r.res));
                end
            end
            res_due = bus.op_valid;
            if (bus.op_valid) begin
                if (exp_q.size() == 0) begin
                    reportUnexpected("op_valid_spurious");
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("op_dataa", 32'(bus.op_dataa), 32'(e.a));
                    checkOutput("op_datab", 32'(bus.op_datab), 32'(e.b));
                    checkOutput("op_add_sub", 32'(bus.op_add_sub), 32'(e.op));
                    checkOutput("op_tag", 32'(bus.op_tag), 32'(tag_model));
                    r.tag = tag_model;
                    r.res = e.res;
                    res_q.push_back(r);
                    tag_model = tag_model + 1'b1;
                    ops_seen++;
                end
            end
        end
    end

    initial begin
        logic [WIDTH-1:0] va [6];
        logic [WIDTH-1:0] vb [6];
        bit               vo [6];
        int run;
        int max_run;
        int ops_before;

        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_dataa   = '0;
        bus.in_datab   = '0;
        bus.in_add_sub = 1'b0;
        bus.issue_en   = 1'b0;
        @(negedge clk);
        #1;
        applyReset();

        $display("[TB] single operation");
        applyStimulus(1'b1, 8'h10, 8'h05, 1'b1, 1'b1);
        checkOutput("no_bypass_op_valid", 32'(bus.op_valid), 32'd0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("single_op_valid", 32'(bus.op_valid), 32'd1);
        checkOutput("single_op_dataa", 32'(bus.op_dataa), 32'h10);
        checkOutput("single_op_datab", 32'(bus.op_datab), 32'h05);
        checkOutput("single_op_tag", 32'(bus.op_tag), 32'd0);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("single_res_valid", 32'(bus.res_valid), 32'd1);
        checkOutput("single_res_tag", 32'(bus.res_tag), 32'd0);
        checkOutput("single_result", 32'(dn_result), 32'h15);
        idle(2, 1'b1);

        $display("[TB] back-to-back stream");
        applyReset();
        va[0] = 8'hFF; vb[0] = 8'h01; vo[0] = 1'b1;
        va[1] = 8'h00; vb[1] = 8'h01; vo[1] = 1'b0;
        for (int i = 2; i < 6; i++) begin
            va[i] = 8'($urandom);
            vb[i] = 8'($urandom);
            vo[i] = 1'($urandom);
        end
        run = 0;
        max_run = 0;
        for (int c = 0; c < 12; c++) begin
            if (c < 6) applyStimulus(1'b1, va[c], vb[c], vo[c], 1'b1);
            else       applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
            if (bus.res_valid) begin
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
        checkOutput("stream_res_run", 32'(max_run), 32'd6);
        checkOutput("stream_last_tag", 32'(bus.res_tag), 32'd5);

        $display("[TB] full queue");
        applyReset();
        ops_before = ops_seen;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        end
        checkOutput("full_count", 32'(bus.count), 32'd4);
        checkOutput("full_in_ready", 32'(bus.in_ready), 32'd0);
        idle(7, 1'b1);
        checkOutput("full_ops_issued", 32'(ops_seen - ops_before), 32'd4);

        $display("[TB] simultaneous push and pop");
        applyReset();
        applyStimulus(1'b1, 8'h21, 8'h12, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'h30, 8'h40, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h7F, 8'h01, 1'b1, 1'b1);
        checkOutput("pushpop_count", 32'(bus.count), 32'd2);
        idle(6, 1'b1);

        $display("[TB] tag wrap");
        applyReset();
        for (int i = 0; i < 18; i++) begin
            applyStimulus(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        end
        idle(4, 1'b1);
        checkOutput("wrap_last_op_tag", 32'(bus.op_tag), 32'd1);
        checkOutput("wrap_last_res_tag", 32'(bus.res_tag), 32'd1);

        $display("[TB] reset mid-operation");
        applyReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        end
        checkOutput("mid_count", 32'(bus.count), 32'd3);
        checkOutput("mid_op_valid", 32'(bus.op_valid), 32'd1);
        checkOutput("mid_res_valid", 32'(bus.res_valid), 32'd1);
        applyReset();
        idle(3, 1'b1);
        applyStimulus(1'b1, 8'h44, 8'h22, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b1);
        checkOutput("post_reset_op_valid", 32'(bus.op_valid), 32'd1);
        checkOutput("post_reset_op_tag", 32'(bus.op_tag), 32'd0);
        idle(3, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                          1'($urandom), 1'($urandom_range(0, 2) != 0));
        end
        idle(10, 1'b1);
        checkOutput("drain_issue_queue", 32'(exp_q.size()), 32'd0);
        checkOutput("drain_result_queue", 32'(res_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
